// File: rtl/data_bus_bridge_if.sv
// External data-memory bus seen by the load/store bridge.
//   master : bridge side, drives the request, samples ack/rdata
//   slave  : memory side, drives ack/rdata
// Signals:
//   bus_req   request, high from issue until ack or abort
//   bus_we    1 = write transaction
//   bus_addr  word-aligned byte address
//   bus_wdata write data (byte stores replicated on all lanes)
//   bus_be    byte enables, bit i = byte lane i (little-endian)
//   bus_ack   one-cycle completion strobe
//   bus_rdata read data, valid with bus_ack
interface data_bus_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_bus_bridge.sv
// Load/store bridge: turns single-cycle core memory accesses into req/ack
// bus transactions, stalls the core until completion, steers byte lanes
// for LDRB/STRB and aborts a transaction that is not acked in time.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   mem_read         core load request
//   mem_write        core store request (wins over mem_read)
//   byte_access      1 = byte access, 0 = word access
//   addr             core data address
//   write_data       core store data
//   read_data        loaded data, held between loads
//   stall            core must hold PC, registers and request inputs
//   bus_error        sticky: some transaction timed out
//   bus              external bus, master side
//
// Parameters:
//   TIMEOUT_CYCLES   WAIT cycles allowed before abort (1..65535)
//   ERR_READ_VALUE   read_data returned by a timed-out load

// Per-lane write steering: byte enable and write byte for one lane.
module data_bus_bridge_lane #(
  parameter int LANE = 0
) (
  input  logic       byte_access,
  input  logic [1:0] lane_sel,
  input  logic [7:0] word_byte,   // this lane's byte of the store word
  input  logic [7:0] low_byte,    // store byte for byte accesses
  output logic       be,
  output logic [7:0] wdata
);
  assign be    = !byte_access || (lane_sel == 2'(LANE));
  // Byte stores are replicated on every lane; bus_be picks the real one.
  assign wdata = byte_access ? low_byte : word_byte;
endmodule

module data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_READ_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        byte_access,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        bus_error,
  data_bus_bridge_if.master bus
);
  localparam int          NUM_LANES = 4;
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Request attributes needed after issue to format the load result.
  typedef struct packed {
    logic       byte_acc;
    logic [1:0] lane;
  } req_t;

  state_t state, state_nxt;
  req_t   lat;
  logic   acc, start, ack_hit, to_hit;
  logic [15:0] cnt;

  logic [NUM_LANES-1:0]      be_nxt;
  logic [NUM_LANES-1:0][7:0] wdata_nxt;
  logic [7:0]                rd_byte;

  assign acc = mem_read | mem_write;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_bus_bridge_lane #(.LANE(i)) u_lane (
      .byte_access (byte_access),
      .lane_sel    (addr[1:0]),
      .word_byte   (write_data[8*i +: 8]),
      .low_byte    (write_data[7:0]),
      .be          (be_nxt[i]),
      .wdata       (wdata_nxt[i])
    );
  end

  assign rd_byte = bus.bus_rdata[8*lat.lane +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    start     = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        stall = acc;
        if (acc) begin
          start     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus.bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= '0;
      read_data     <= '0;
      bus_error     <= 1'b0;
      cnt           <= '0;
      lat           <= '0;
    end else begin
      if (start) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= mem_write;
        bus.bus_addr  <= {addr[31:2], 2'b00};
        bus.bus_wdata <= wdata_nxt;
        bus.bus_be    <= be_nxt;
        cnt           <= '0;
        lat           <= '{byte_acc: byte_access, lane: addr[1:0]};
      end else if (state == WAIT) begin
        cnt <= cnt + 16'd1;
      end

      if (ack_hit) begin
        bus.bus_req <= 1'b0;
        if (!bus.bus_we)
          read_data <= lat.byte_acc ? {24'h0, rd_byte} : bus.bus_rdata;
      end

      if (to_hit) begin
        bus.bus_req <= 1'b0;
        bus_error   <= 1'b1;
        if (!bus.bus_we) read_data <= ERR_READ_VALUE;
      end
    end
  end
endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;
  localparam int          TO   = 4;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_req_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stall_n;
  } exp_done_t;

  typedef struct {
    int          d;       // idle WAIT cycles before ack; d >= TO means never ack
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, byte_access = 1'b0;
  logic [31:0] addr = '0, write_data = '0;
  logic [31:0] read_data;
  logic        stall, bus_error;

  data_bus_bridge_if bus();

  data_bus_bridge #(.TIMEOUT_CYCLES(TO), .ERR_READ_VALUE(ERRV)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .byte_access (byte_access),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .stall       (stall),
    .bus_error   (bus_error),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  exp_req_t  exp_req_q[$];
  exp_done_t exp_done_q[$];
  resp_t     resp_q[$];

  int          n_cmp = 0, n_err = 0, done_cnt = 0;
  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // Reference model: derive bus fields and core-visible result from the rules.
  task automatic access(input logic rd, input logic wr, input logic bt,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int d, input logic [31:0] rdat);
    exp_req_t  er;
    exp_done_t ed;
    resp_t     rs;
    int        lane, start_cnt;
    bit        timed;
    lane     = int'(a % 4);
    er.we    = wr;
    er.addr  = a & 32'hFFFF_FFFC;
    er.be    = bt ? 4'(1 << lane) : 4'hF;
    er.wdata = bt ? wd[7:0] * 32'h0101_0101 : wd;
    timed    = (d >= TO);
    if (timed) m_err = 1'b1;
    if (!wr) m_rd = timed ? ERRV : (bt ? (rdat >> (8*lane)) & 32'hFF : rdat);
    ed.rd      = m_rd;
    ed.err     = m_err;
    ed.stall_n = 1 + (timed ? TO : d + 1);
    rs.d       = d;
    rs.rdata   = rdat;
    exp_req_q.push_back(er);
    exp_done_q.push_back(ed);
    resp_q.push_back(rs);
    mem_read = rd; mem_write = wr; byte_access = bt; addr = a; write_data = wd;
    start_cnt = done_cnt;
    for (int i = 0; i < 40 && done_cnt == start_cnt; i++) begin
      @(negedge clk); #2;
    end
    if (done_cnt == start_cnt) begin
      n_cmp++; n_err++;
      $display("FAIL access_done: no completion within 40 cycles (addr %h)", a);
      finish_run();
    end
  endtask

  // Drop the request for n cycles, then leave the bench early in an IDLE cycle.
  task automatic idle(input int n);
    mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; write_data = $urandom; byte_access = 1'($urandom);
    repeat (n) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Bus slave: ack after the scripted delay, sometimes hold ack into DONE.
  initial begin
    resp_t r;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.bus_req && !reset) begin
        if (resp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL resp_queue: bus_req with no scripted response");
          for (int i = 0; i < 20 && bus.bus_req; i++) @(negedge clk);
        end else begin
          r = resp_q.pop_front();
          if (r.d >= TO) begin
            for (int i = 0; i < TO + 4 && bus.bus_req; i++) @(negedge clk);
          end else begin
            repeat (r.d) @(negedge clk);
            bus.bus_ack = 1'b1;
            bus.bus_rdata = r.rdata;
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
              bus.bus_rdata = $urandom;
              @(negedge clk);
            end
            bus.bus_ack = 1'b0;
            bus.bus_rdata = $urandom;
          end
        end
      end
    end
  end

  // Monitor: checks each issued request and each completion.
  exp_req_t  cur;
  exp_done_t edn;
  logic      prev_req = 1'b0, prev_stall = 1'b0;
  int        scnt = 0;

  initial begin
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        prev_req = 1'b0; prev_stall = 1'b0; scnt = 0;
      end else begin
        if (bus.bus_req && !prev_req) begin
          if (exp_req_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL req_queue: unexpected bus_req addr %h", bus.bus_addr);
          end else cur = exp_req_q.pop_front();
        end
        if (bus.bus_req) begin
          chk("bus_we",    32'(bus.bus_we), 32'(cur.we));
          chk("bus_addr",  bus.bus_addr,    cur.addr);
          chk("bus_wdata", bus.bus_wdata,   cur.wdata);
          chk("bus_be",    32'(bus.bus_be), 32'(cur.be));
        end
        if (stall) scnt++;
        else if (prev_stall) begin
          if (exp_done_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_queue: unexpected completion");
          end else begin
            edn = exp_done_q.pop_front();
            chk("read_data",    read_data,       edn.rd);
            chk("bus_error",    32'(bus_error),  32'(edn.err));
            chk("stall_cycles", 32'(scnt),       32'(edn.stall_n));
          end
          scnt = 0;
          done_cnt++;
        end
        prev_req = bus.bus_req;
        prev_stall = stall;
      end
    end
  end

  initial begin
    exp_req_t er;
    resp_t    rs;
    // Reset state, with a request pending to prove stall is gated.
    mem_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall",     32'(stall),       32'd0);
    chk("rst_bus_req",   32'(bus.bus_req), 32'd0);
    chk("rst_bus_we",    32'(bus.bus_we),  32'd0);
    chk("rst_bus_addr",  bus.bus_addr,     32'd0);
    chk("rst_bus_wdata", bus.bus_wdata,    32'd0);
    chk("rst_bus_be",    32'(bus.bus_be),  32'd0);
    chk("rst_read_data", read_data,        32'd0);
    chk("rst_bus_error", 32'(bus_error),   32'd0);
    mem_read = 1'b0;
    #2 reset = 1'b0;
    idle(1);

    // Directed cases.
    access(1, 0, 0, 32'h0000_1004, 32'h0BAD_F00D, 1, 32'hCAFE_BABE);
    idle(1);
    access(0, 1, 1, 32'h0000_2003, 32'h1234_56A5, 0, 32'h7777_7777);
    idle(2);
    access(1, 0, 1, 32'h0000_0501, 32'h0,         0, 32'h1122_3344);
    access(1, 1, 0, 32'h0000_0040, 32'hA1B2_C3D4, 2, 32'h9999_9999);
    access(1, 0, 0, 32'h0000_0088, 32'h0,      TO-1, 32'h1357_9BDF);
    idle(1);
    access(1, 0, 0, 32'h0000_0080, 32'h0,         9, 32'h2468_ACE0);
    access(1, 0, 1, 32'h0000_00C2, 32'h0,         0, 32'h00AB_0000);

    // Randomized traffic, mixing back-to-back and gapped accesses.
    for (int t = 0; t < 150; t++) begin
      logic rd, wr;
      int   k;
      k  = $urandom_range(0, 2);
      rd = (k != 1);
      wr = (k != 0);
      access(rd, wr, 1'($urandom), $urandom, $urandom,
             $urandom_range(0, TO + 1), $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end
    // Leave a known nonzero load result behind the reset test.
    access(1, 0, 0, 32'h0000_0100, 32'h0, 0, 32'h5A5A_0001);
    idle(2);

    // Reset in the middle of WAIT, then a late ack.
    er.we = 1'b0; er.addr = 32'h0000_3008; er.wdata = 32'h0; er.be = 4'hF;
    exp_req_q.push_back(er);
    rs.d = 2; rs.rdata = 32'h5555_AAAA;
    resp_q.push_back(rs);
    mem_read = 1'b1; mem_write = 1'b0; byte_access = 1'b0;
    addr = 32'h0000_3008; write_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #3;
    reset = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("midrst_bus_req",   32'(bus.bus_req), 32'd0);
    chk("midrst_stall",     32'(stall),       32'd0);
    chk("midrst_read_data", read_data,        32'd0);
    chk("midrst_bus_error", 32'(bus_error),   32'd0);
    @(negedge clk); #3;
    reset = 1'b0;
    m_rd = '0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("late_ack_bus_req",   32'(bus.bus_req), 32'd0);
      chk("late_ack_stall",     32'(stall),       32'd0);
      chk("late_ack_read_data", read_data,        32'd0);
    end

    chk("pending_requests",    32'(exp_req_q.size()),  32'd0);
    chk("pending_completions", 32'(exp_done_q.size()), 32'd0);
    finish_run();
  end
endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
Load/store bridge between the ARM core datapath (data address, store data, loaded data) and a handshaked external data-memory bus. Converts single-cycle core memory accesses into req/ack bus transactions. Stalls the core until completion, handles byte (LDRB/STRB) lane steering, and bounds each transaction with a timeout.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for bus_ack before the transaction is aborted (1..65535)
ERR_READ_VALUE, 32'h0000_0000, read_data returned on a timed-out load

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  core requests a load this cycle
mem_write  input  1  core requests a store this cycle
byte_access  input  1  1 = byte access, 0 = word access
addr  input  32  core data address (ALU result)
write_data  input  32  core store data (register Rd)
read_data  output  32  loaded data to the core result mux
stall  output  1  core must hold PC, registers and request inputs
bus_req  output  1  bus transaction request
bus_we  output  1  1 = write transaction
bus_addr  output  32  word-aligned bus address, {addr[31:2],2'b00}
bus_wdata  output  32  bus write data
bus_be  output  4  byte enables, bit i = byte lane i (little-endian)
bus_ack  input  1  bus completion strobe, one cycle
bus_rdata  input  32  bus read data, valid with bus_ack
bus_error  output  1  sticky: a transaction timed out

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. Reset forces state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, read_data=0, bus_error=0, timeout counter=0. stall is 0 while reset is high.
- Access qualifier: acc = mem_read | mem_write. Both high is a write; mem_read is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - stall = acc, combinational, same cycle.
  - If acc, register bus_req=1, bus_we, bus_addr, bus_wdata and bus_be, clear the counter, go WAIT.
  - bus_ack in IDLE is ignored.
- WAIT:
  - stall=1. All bus outputs are held stable.
  - Counter increments each cycle.
  - On bus_ack: bus_req=0, capture the formatted read data into read_data if it was a load, go DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack: bus_req=0, bus_error=1 (sticky until reset), read_data=ERR_READ_VALUE for a load, go DONE.
  - If ack and timeout occur in the same cycle, ack wins and bus_error is not set.
- DONE:
  - stall=0 for exactly one cycle; the core commits at this edge. read_data is valid.
  - Next state is unconditionally IDLE. An access presented in the following cycle is a new transaction.
  - Minimum latency is 3 cycles per access: IDLE, WAIT with ack on the first WAIT cycle, DONE.
- Request inputs: the core holds mem_read, mem_write, byte_access, addr and write_data stable while stall=1. The bridge latches them in IDLE and does not re-sample them in WAIT.
- Word access:
  - bus_be=4'b1111, bus_wdata=write_data.
  - Load: read_data=bus_rdata.
  - addr[1:0] is ignored; no rotation.
- Byte access, lane k=addr[1:0]:
  - bus_be=4'b0001<<k, bus_wdata={4{write_data[7:0]}}.
  - Load: read_data = zero-extended bus_rdata[8k+7:8k].
- read_data holds its value between loads. Stores do not change it.
- Reset mid-WAIT: the transaction is abandoned immediately and bus_req drops asynchronously. A late bus_ack after reset is ignored, since the FSM is in IDLE.

Test Plan:
- Word load, addr=0x0000_1004, ack after 2 WAIT cycles with bus_rdata=0xCAFE_BABE -> bus_addr=0x1004, bus_be=4'hF, bus_we=0, stall high for 3 cycles, then low one cycle with read_data=0xCAFE_BABE.
- Byte store, addr=0x0000_2003, write_data=0x1234_56A5 -> bus_be=4'b1000, bus_wdata=0xA5A5_A5A5, bus_addr=0x2000, bus_we=1; read_data unchanged.
- Byte load, addr=0x...01, bus_rdata=0x11223344 -> read_data=0x0000_0033.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> bus_req low after 4 WAIT cycles, bus_error=1 and stays 1, read_data=ERR_READ_VALUE, stall released one cycle.
- mem_read and mem_write both high -> bus_we=1. Back-to-back accesses -> second bus_req rises in the cycle after DONE.
- Reset asserted mid-WAIT, then bus_ack pulses -> bus_req=0 immediately, state IDLE, read_data=0, ack ignored.
